// File: rtl/fir_inverse_deconv.sv
// fir_inverse_deconv: serial inverse filter for the fixed FIR h = [1, 2, 3, 4].
// Recovers x[n] = y[n] - sum_{k=1..N-1} h[k]*x[n-k], one multiply-subtract per cycle.
//
// state | meaning
// IDLE  | waiting for y_in, y_ready high
// MAC   | subtracting h[k]*hist[k-1] for k = 1..N-1
// OUT   | x_out/x_valid held until x_ready
module fir_inverse_deconv #(
  parameter int N           = 4,
  parameter int DATA_WIDTH  = 16,
  parameter int COEFF_WIDTH = 16,
  parameter int Y_WIDTH     = DATA_WIDTH + COEFF_WIDTH + 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic signed [Y_WIDTH-1:0]    y_in,
  input  logic                         y_valid,
  output logic                         y_ready,
  output logic signed [DATA_WIDTH-1:0] x_out,
  output logic                         x_valid,
  input  logic                         x_ready,
  output logic                         sat,
  output logic                         busy
);

  localparam int ACC_W  = Y_WIDTH + COEFF_WIDTH + 2;
  localparam int PROD_W = DATA_WIDTH + COEFF_WIDTH;
  localparam int KW     = $clog2(N);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MAC  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic signed [DATA_WIDTH-1:0] X_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] X_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  logic [1:0]                   state;
  logic [KW-1:0]                k;
  logic signed [ACC_W-1:0]      acc;
  logic signed [DATA_WIDTH-1:0] hist [N-1];

  logic signed [DATA_WIDTH-1:0]  tap;
  logic signed [COEFF_WIDTH-1:0] coeff;
  logic signed [PROD_W-1:0]      prod;
  logic signed [ACC_W-1:0]       acc_sub;
  logic [ACC_W-DATA_WIDTH:0]     acc_hi;
  logic                          clip;
  logic signed [DATA_WIDTH-1:0]  x_clip;

  assign y_ready = (state == S_IDLE);
  assign x_valid = (state == S_OUT);
  assign busy    = (state == S_MAC) || (state == S_OUT);

  // Datapath: pick hist[k-1], subtract h[k]*hist[k-1] at full width, then clip to DATA_WIDTH.
  always_comb begin
    tap = '0;
    for (int i = 0; i < N - 1; i++) begin
      if (k == KW'(i + 1)) tap = hist[i];
    end
    coeff   = COEFF_WIDTH'(k) + COEFF_WIDTH'(1);
    prod    = PROD_W'(tap) * PROD_W'(coeff);
    acc_sub = acc - ACC_W'(prod);
    // Value fits when every bit from the DATA_WIDTH sign bit upward agrees.
    acc_hi  = acc_sub[ACC_W-1:DATA_WIDTH-1];
    clip    = !((&acc_hi) || !(|acc_hi));
    if (clip) x_clip = acc_sub[ACC_W-1] ? X_MIN : X_MAX;
    else      x_clip = acc_sub[DATA_WIDTH-1:0];
  end

  // FSM, accumulator, history and output registers; flush overrides any handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      k     <= '0;
      acc   <= '0;
      x_out <= '0;
      sat   <= 1'b0;
      for (int i = 0; i < N - 1; i++) hist[i] <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      k     <= '0;
      acc   <= '0;
      sat   <= 1'b0;
      for (int i = 0; i < N - 1; i++) hist[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (y_valid) begin
            acc   <= ACC_W'(y_in);
            k     <= KW'(1);
            state <= S_MAC;
          end
        end
        S_MAC: begin
          acc <= acc_sub;
          k   <= k + KW'(1);
          if (k == KW'(N - 1)) begin
            // The clipped sample is what feeds back into later samples.
            x_out   <= x_clip;
            hist[0] <= x_clip;
            for (int i = 1; i < N - 1; i++) hist[i] <= hist[i-1];
            if (clip) sat <= 1'b1;
            k     <= '0;
            state <= S_OUT;
          end
        end
        S_OUT: begin
          if (x_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
